median_filter_sched: RTL and testbench

- Burst scheduler that shares one median_filter instance between two sample requesters (ch0, ch1).
- Grants whole bursts round-robin and forwards samples to the filter's dat_i/val_i.
- Inserts a val_i-low gap between bursts so the filter window restarts cleanly.
- Routes filter outputs back to the owning channel using an in-order tag FIFO.

---
 rtl/median_filter_sched_if.sv | 37 +++
 rtl/median_filter_sched.sv | 154 +++++++++++++++
 tb/tb_median_filter_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/median_filter_sched_if.sv
// Requester, filter and result signals of the median filter burst scheduler.
// The slave modport is the scheduler's view; the master modport is its surroundings.
interface median_filter_sched_if #(
  parameter int unsigned WORD_LEN = 8
);
  logic [WORD_LEN-1:0] s0_dat;
  logic                s0_val;
  logic                s0_last;
  logic                s0_rdy;
  logic [WORD_LEN-1:0] s1_dat;
  logic                s1_val;
  logic                s1_last;
  logic                s1_rdy;
  logic [WORD_LEN-1:0] f_dat_o;
  logic                f_val_o;
  logic [WORD_LEN-1:0] f_dat_i;
  logic                f_val_i;
  logic [WORD_LEN-1:0] m0_dat;
  logic                m0_val;
  logic [WORD_LEN-1:0] m1_dat;
  logic                m1_val;
  logic                grant;
  logic                busy;
  logic                err;

  modport slave (
    input  s0_dat, s0_val, s0_last, s1_dat, s1_val, s1_last, f_dat_i, f_val_i,
    output s0_rdy, s1_rdy, f_dat_o, f_val_o, m0_dat, m0_val, m1_dat, m1_val,
           grant, busy, err
  );

  modport master (
    output s0_dat, s0_val, s0_last, s1_dat, s1_val, s1_last, f_dat_i, f_val_i,
    input  s0_rdy, s1_rdy, f_dat_o, f_val_o, m0_dat, m0_val, m1_dat, m1_val,
           grant, busy, err
  );
endinterface

// File: rtl/median_filter_sched.sv
// Shares one median filter between two requesters: round-robin whole-burst grants,
// idle gaps between bursts, and an in-order tag FIFO routing results back.
module median_filter_sched #(
  parameter int unsigned WORD_LEN  = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned GAP       = 5,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  median_filter_sched_if.slave  bus
);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_GAP} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                rr_q, rr_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [WORD_LEN-1:0] f_dat_q, f_dat_d;
  logic                f_val_q, f_val_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WORD_LEN-1:0] m0_dat_q, m0_dat_d;
  logic                m0_val_q, m0_val_d;
  logic [WORD_LEN-1:0] m1_dat_q, m1_dat_d;
  logic                m1_val_q, m1_val_d;
  logic                err_q, err_d;
  logic                tag_mem_q [TAG_DEPTH];

  logic                tag_full_c, tag_empty_c;
  logic                s0_rdy_c, s1_rdy_c;
  logic                hs_c, push_c, pop_c, tag_out_c, sel_last_c;
  logic [WORD_LEN-1:0] sel_dat_c;

  // Ready depends only on registered state, never on the requester's valid.
  assign tag_full_c  = (cnt_q == CW'(TAG_DEPTH));
  assign tag_empty_c = (cnt_q == '0);
  assign s0_rdy_c    = (state_q == ST_STREAM) & ~grant_q & ~tag_full_c;
  assign s1_rdy_c    = (state_q == ST_STREAM) &  grant_q & ~tag_full_c;
  assign hs_c        = (bus.s0_val & s0_rdy_c) | (bus.s1_val & s1_rdy_c);
  assign sel_dat_c   = grant_q ? bus.s1_dat  : bus.s0_dat;
  assign sel_last_c  = grant_q ? bus.s1_last : bus.s0_last;
  assign push_c      = hs_c;
  assign pop_c       = bus.f_val_i & ~tag_empty_c;
  assign tag_out_c   = tag_mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    f_val_d  = hs_c;
    f_dat_d  = hs_c ? sel_dat_c : f_dat_q;
    wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_c) - CW'(pop_c);
    m0_val_d = pop_c & ~tag_out_c;
    m1_val_d = pop_c &  tag_out_c;
    m0_dat_d = (pop_c & ~tag_out_c) ? bus.f_dat_i : m0_dat_q;
    m1_dat_d = (pop_c &  tag_out_c) ? bus.f_dat_i : m1_dat_q;
    err_d    = err_q | (bus.f_val_i & tag_empty_c);

    case (state_q)
      ST_IDLE: begin
        if (bus.s0_val | bus.s1_val) begin
          state_d = ST_STREAM;
          beat_d  = '0;
          // On a tie the pointer names the last tie winner; the other side wins.
          if (bus.s0_val & bus.s1_val) begin
            grant_d = ~rr_q;
            rr_d    = ~rr_q;
          end else begin
            grant_d = bus.s1_val;
          end
        end
      end
      ST_STREAM: begin
        if (hs_c) begin
          beat_d = beat_q + BW'(1);
          if (sel_last_c | (beat_q == BW'(MAX_BURST - 1))) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b1;
      beat_q   <= '0;
      gap_q    <= '0;
      f_dat_q  <= '0;
      f_val_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      m0_dat_q <= '0;
      m0_val_q <= 1'b0;
      m1_dat_q <= '0;
      m1_val_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      f_dat_q  <= f_dat_d;
      f_val_q  <= f_val_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      m0_dat_q <= m0_dat_d;
      m0_val_q <= m0_val_d;
      m1_dat_q <= m1_dat_d;
      m1_val_q <= m1_val_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push_c) tag_mem_q[wr_ptr_q] <= grant_q;
  end

  assign bus.s0_rdy  = s0_rdy_c;
  assign bus.s1_rdy  = s1_rdy_c;
  assign bus.f_dat_o = f_dat_q;
  assign bus.f_val_o = f_val_q;
  assign bus.m0_dat  = m0_dat_q;
  assign bus.m0_val  = m0_val_q;
  assign bus.m1_dat  = m1_dat_q;
  assign bus.m1_val  = m1_val_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != ST_IDLE) | ~tag_empty_c;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_median_filter_sched.sv
// Randomized bench for median_filter_sched against a queue-based behavioural model
// of burst scheduling, gaps, tag routing, backpressure, spurious outputs and reset.
module tb_median_filter_sched;
  localparam int unsigned WL = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned GP = 5;
  localparam int unsigned TD = 4;
  localparam int NCYC = 2500;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  median_filter_sched_if #(.WORD_LEN(WL)) bus ();

  median_filter_sched #(
    .WORD_LEN(WL), .MAX_BURST(MB), .GAP(GP), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: who owns the filter, how far the burst has got, gap left.
  bit          m_stream;
  int          m_owner;
  int          m_rr;
  int          m_beats;
  int          m_gap_left;
  bit          m_tags[$];
  bit          e_fval, e_m0val, e_m1val, e_err;
  logic [WL-1:0] e_fdat, e_m0dat, e_m1dat;

  logic [WL-1:0] src0[$];
  logic [WL-1:0] src1[$];
  logic [WL-1:0] pend[$];

  function automatic void model_reset();
    m_stream = 1'b0; m_owner = 0; m_rr = 1; m_beats = 0; m_gap_left = 0;
    m_tags.delete();
    e_fval = 1'b0; e_m0val = 1'b0; e_m1val = 1'b0; e_err = 1'b0;
    e_fdat = '0; e_m0dat = '0; e_m1dat = '0;
  endfunction

  function automatic bit m_rdy(input int ch);
    return m_stream && (m_owner == ch) && (m_tags.size() < int'(TD));
  endfunction

  function automatic bit m_busy();
    return m_stream || (m_gap_left > 0) || (m_tags.size() != 0);
  endfunction

  task automatic model_step();
    bit h0, h1, l, tg;
    logic [WL-1:0] d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    h0 = bus.s0_val && m_rdy(0);
    h1 = bus.s1_val && m_rdy(1);
    d  = h1 ? bus.s1_dat  : bus.s0_dat;
    l  = h1 ? bus.s1_last : bus.s0_last;
    e_fval = h0 || h1;
    if (e_fval) e_fdat = d;
    e_m0val = 1'b0;
    e_m1val = 1'b0;
    if (bus.f_val_i) begin
      if (m_tags.size() == 0) e_err = 1'b1;
      else begin
        tg = m_tags.pop_front();
        if (tg) begin e_m1val = 1'b1; e_m1dat = bus.f_dat_i; end
        else    begin e_m0val = 1'b1; e_m0dat = bus.f_dat_i; end
      end
    end
    if (h0 || h1) m_tags.push_back(h1);
    if (h0) void'(src0.pop_front());
    if (h1) void'(src1.pop_front());
    if (m_gap_left > 0) m_gap_left--;
    else if (m_stream) begin
      if (h0 || h1) begin
        m_beats++;
        if (l || m_beats == int'(MB)) begin
          m_stream = 1'b0;
          m_gap_left = int'(GP);
        end
      end
    end else if (bus.s0_val || bus.s1_val) begin
      if (bus.s0_val && bus.s1_val) begin
        m_owner = 1 - m_rr;
        m_rr = m_owner;
      end else begin
        m_owner = bus.s1_val ? 1 : 0;
      end
      m_stream = 1'b1;
      m_beats = 0;
    end
  endtask

  task automatic fill_src(input int ch, input int len);
    for (int i = 0; i < len; i++) begin
      if (ch == 0) src0.push_back(WL'($urandom));
      else         src1.push_back(WL'($urandom));
    end
  endtask

  initial begin
    bit rst_pending, withhold, spur_win;
    rst_pending = 1'b0;
    rst_n = 1'b0;
    bus.s0_dat = '0; bus.s0_val = 1'b0; bus.s0_last = 1'b0;
    bus.s1_dat = '0; bus.s1_val = 1'b0; bus.s1_last = 1'b0;
    bus.f_dat_i = '0; bus.f_val_i = 1'b0;
    model_reset();
    // Both channels start with a 5-beat burst to exercise the first tie.
    fill_src(0, 5);
    fill_src(1, 5);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_eq("f_val_o", 32'(bus.f_val_o), 32'(e_fval));
      check_eq("f_dat_o", 32'(bus.f_dat_o), 32'(e_fdat));
      check_eq("m0_val",  32'(bus.m0_val),  32'(e_m0val));
      check_eq("m0_dat",  32'(bus.m0_dat),  32'(e_m0dat));
      check_eq("m1_val",  32'(bus.m1_val),  32'(e_m1val));
      check_eq("m1_dat",  32'(bus.m1_dat),  32'(e_m1dat));
      check_eq("grant",   32'(bus.grant),   32'(m_owner));
      check_eq("busy",    32'(bus.busy),    32'(m_busy()));
      check_eq("err",     32'(bus.err),     32'(e_err));
      check_eq("s0_rdy",  32'(bus.s0_rdy),  32'(m_rdy(0)));
      check_eq("s1_rdy",  32'(bus.s1_rdy),  32'(m_rdy(1)));

      if (c == 900 || c == 1700) rst_pending = 1'b1;
      if (c < 3) rst_n = 1'b0;
      else if (rst_pending && m_stream && m_beats == 2) begin
        rst_n = 1'b0;
        rst_pending = 1'b0;
      end else rst_n = 1'b1;

      // Filter stub: returns forwarded samples in order, with stalls and stray outputs.
      withhold = ((c / 150) % 3) == 2;
      spur_win = (c >= 1000) && (c < 1200);
      bus.f_val_i = 1'b0;
      bus.f_dat_i = WL'($urandom);
      if (!withhold && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.f_val_i = 1'b1;
        bus.f_dat_i = pend.pop_front() ^ 8'h3C;
      end else if (spur_win && pend.size() == 0 && $urandom_range(0, 19) == 0) begin
        bus.f_val_i = 1'b1;
      end
      if (e_fval) pend.push_back(e_fdat);

      if (src0.size() == 0 && $urandom_range(0, 19) == 0) fill_src(0, int'($urandom_range(1, 10)));
      if (src1.size() == 0 && $urandom_range(0, 19) == 0) fill_src(1, int'($urandom_range(1, 10)));
      bus.s0_val  = (src0.size() > 0) && ($urandom_range(0, 9) != 0);
      bus.s0_dat  = (src0.size() > 0) ? src0[0] : WL'($urandom);
      bus.s0_last = (src0.size() > 0) ? (src0.size() == 1) : 1'($urandom);
      bus.s1_val  = (src1.size() > 0) && ($urandom_range(0, 9) != 0);
      bus.s1_dat  = (src1.size() > 0) ? src1[0] : WL'($urandom);
      bus.s1_last = (src1.size() > 0) ? (src1.size() == 1) : 1'($urandom);

      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
